perf_counter_bank: RTL and testbench

Synthesizable, parametrised bank of event counters for on-chip CPU performance monitoring: cycles, commits, cache requests and hits, branch mispredictions, stalls and bubbles. Each channel counts single-cycle event strobes from the datapath and caches. A snapshot mechanism freezes a consistent copy of all counters. A ready/valid dump sequencer then streams that copy out one channel at a time to a debug or trace consumer. It sits beside `cpu`, `icache` and `dcache` in the top level and replaces ad hoc testbench-side counting.

---
 rtl/perf_counter_bank.sv | 152 +++++++++++++++
 tb/tb_perf_counter_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with wrap/saturate overflow, a frozen snapshot copy,
// and a ready/valid sequencer that streams the snapshot out one channel per beat.
module perf_counter_bank #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] inc,
    input  logic              en,
    input  logic              sat_mode,
    input  logic              clear,
    input  logic              snap,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [IDX_W-1:0]  dump_ch,
    output logic [CNT_W-1:0]  dump_data,
    output logic              dump_ovf,
    output logic              dump_done,
    output logic              busy,
    output logic [NUM_CH-1:0] ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              done_p1, done_nxt;

    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt  [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [CNT_W-1:0]  snap_cnt [NUM_CH];
    logic [NUM_CH-1:0] snap_ovf;

    // Increment with overflow policy: at all-ones either wrap to zero or hold.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] v,
                                                     input logic             sat);
        if (&v) begin
            return sat ? v : '0;
        end
        return v + CNT_W'(1);
    endfunction

    function automatic logic at_top(input logic [CNT_W-1:0] v);
        return &v;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = next_count(cnt[i], sat_mode);
        end
    end

    // Live counters: rst and clear share the same effect and both beat counting.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ovf_q <= '0;
        end else if (en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (inc[i]) begin
                    cnt[i] <= cnt_nxt[i];
                    if (at_top(cnt[i])) begin
                        ovf_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Snapshot samples pre-update values, so snap+clear keeps the old counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_cnt[i] <= '0;
            end
            snap_ovf <= '0;
        end else if (snap && state == IDLE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_cnt[i] <= cnt[i];
            end
            snap_ovf <= ovf_q;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = DUMP;
                    idx_nxt   = '0;
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    if (idx == IDX_W'(NUM_CH - 1)) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            done_p1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            done_p1 <= done_nxt;
        end
    end

    // Outputs decode registered state only; IDLE forces the beat fields to zero.
    always_comb begin
        dump_valid = (state == DUMP);
        busy       = (state == DUMP);
        dump_ch    = '0;
        dump_data  = '0;
        dump_ovf   = 1'b0;
        if (state == DUMP) begin
            dump_ch   = idx;
            dump_data = snap_cnt[idx];
            dump_ovf  = snap_ovf[idx];
        end
    end

    assign dump_done = done_p1;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a table of count/overflow vectors plus
// hand-written sequences for snapshot, backpressure, busy-time commands and reset.
module tb_perf_counter_bank;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] inc;
    logic              en;
    logic              sat_mode;
    logic              clear;
    logic              snap;
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [IDX_W-1:0]  dump_ch;
    logic [CNT_W-1:0]  dump_data;
    logic              dump_ovf;
    logic              dump_done;
    logic              busy;
    logic [NUM_CH-1:0] ovf;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .inc(inc), .en(en), .sat_mode(sat_mode),
        .clear(clear), .snap(snap), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_ch(dump_ch), .dump_data(dump_data),
        .dump_ovf(dump_ovf), .dump_done(dump_done), .busy(busy), .ovf(ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [CNT_W-1:0]  cap_d [NUM_CH];
    logic [NUM_CH-1:0] cap_o;

    typedef struct {
        logic             sat;
        int               ch;
        int               n;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask, input int n);
        inc = mask;
        en  = 1'b1;
        repeat (n) tick();
        inc = '0;
    endtask

    // Channel i receives exactly i events.
    task automatic load_ramp();
        en = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < NUM_CH; i++) inc[i] = (i > c);
            tick();
        end
        inc = '0;
    endtask

    // Start a dump (optionally with snap/clear on the same edge) and capture every beat.
    task automatic run_dump(input logic do_snap, input logic do_clear);
        snap       = do_snap;
        clear      = do_clear;
        dump_start = 1'b1;
        dump_ready = 1'b1;
        tick();
        snap       = 1'b0;
        clear      = 1'b0;
        dump_start = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            check("beat_valid", 32'(dump_valid), 32'd1);
            check("beat_ch", 32'(dump_ch), 32'(k));
            cap_d[k] = dump_data;
            cap_o[k] = dump_ovf;
            tick();
        end
        check("dump_done", 32'(dump_done), 32'd1);
        check("busy_after_dump", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hs;
        int dones;
        logic pv, pr, rdy;
        logic [IDX_W-1:0] pch;
        logic [CNT_W-1:0] pdata;

        vecs[0] = '{sat: 1'b0, ch: 0, n: 17, exp_cnt: 4'd1,  exp_ovf: 1'b1};
        vecs[1] = '{sat: 1'b1, ch: 2, n: 20, exp_cnt: 4'd15, exp_ovf: 1'b1};
        vecs[2] = '{sat: 1'b0, ch: 3, n: 5,  exp_cnt: 4'd5,  exp_ovf: 1'b0};
        vecs[3] = '{sat: 1'b0, ch: 5, n: 16, exp_cnt: 4'd0,  exp_ovf: 1'b1};
        vecs[4] = '{sat: 1'b1, ch: 6, n: 15, exp_cnt: 4'd15, exp_ovf: 1'b0};
        vecs[5] = '{sat: 1'b0, ch: 7, n: 33, exp_cnt: 4'd1,  exp_ovf: 1'b1};

        rst = 1'b1; inc = '0; en = 1'b0; sat_mode = 1'b0; clear = 1'b0;
        snap = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_ch", 32'(dump_ch), 32'd0);
        check("rst_data", 32'(dump_data), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            clear_all();
            sat_mode = vecs[v].sat;
            pulse(NUM_CH'(1) << vecs[v].ch, vecs[v].n);
            check("vec_live_ovf", 32'(ovf), 32'(vecs[v].exp_ovf) << vecs[v].ch);
            run_dump(1'b1, 1'b0);
            check("vec_cnt", 32'(cap_d[vecs[v].ch]), 32'(vecs[v].exp_cnt));
            check("vec_snap_ovf", 32'(cap_o[vecs[v].ch]), 32'(vecs[v].exp_ovf));
            check("vec_other_ch", 32'(cap_d[(vecs[v].ch + 1) % NUM_CH]), 32'd0);
        end

        // en low gates counting
        clear_all();
        sat_mode = 1'b0;
        inc = 8'h03; en = 1'b0;
        repeat (3) tick();
        inc = '0;
        run_dump(1'b1, 1'b0);
        check("en_low_ch0", 32'(cap_d[0]), 32'd0);
        check("en_low_ch1", 32'(cap_d[1]), 32'd0);

        // saturate, then clear beats a simultaneous strobe
        clear_all();
        sat_mode = 1'b1;
        pulse(8'h04, 20);
        check("sat_ovf", 32'(ovf), 32'h04);
        clear = 1'b1; inc = 8'h04; en = 1'b1;
        tick();
        clear = 1'b0; inc = '0;
        check("clr_ovf", 32'(ovf), 32'd0);
        run_dump(1'b1, 1'b0);
        check("clr_cnt2", 32'(cap_d[2]), 32'd0);
        check("clr_snap_ovf2", 32'(cap_o[2]), 32'd0);
        sat_mode = 1'b0;

        // snap together with clear
        clear_all();
        load_ramp();
        run_dump(1'b1, 1'b1);
        for (int i = 0; i < NUM_CH; i++) check("snapclr_data", 32'(cap_d[i]), 32'(i));
        run_dump(1'b1, 1'b0);
        for (int i = 0; i < NUM_CH; i++) check("snapclr_live", 32'(cap_d[i]), 32'd0);
        check("snapclr_ovf", 32'(ovf), 32'd0);

        // backpressure with ready pattern 1,0,0,1
        clear_all();
        load_ramp();
        pulse(8'hFF, 3);
        snap = 1'b1; dump_start = 1'b1; dump_ready = 1'b0;
        tick();
        snap = 1'b0; dump_start = 1'b0;
        hs = 0; dones = 0; pv = 1'b0; pr = 1'b0; pch = '0; pdata = '0;
        for (int k = 0; k < 40; k++) begin
            rdy = (k % 4 == 0) || (k % 4 == 3);
            if (dump_valid) begin
                if (pv && !pr) begin
                    check("bp_hold_ch", 32'(dump_ch), 32'(pch));
                    check("bp_hold_data", 32'(dump_data), 32'(pdata));
                end
                check("bp_ch_order", 32'(dump_ch), 32'(hs));
            end
            if (dump_valid && rdy) begin
                check("bp_data", 32'(dump_data), 32'(hs + 3));
                hs++;
            end
            if (dump_done) dones++;
            dump_ready = rdy;
            pv = dump_valid; pr = rdy; pch = dump_ch; pdata = dump_data;
            tick();
        end
        dump_ready = 1'b0;
        check("bp_handshakes", 32'(hs), 32'(NUM_CH));
        check("bp_done_pulses", 32'(dones), 32'd1);
        check("bp_busy_end", 32'(busy), 32'd0);

        // snap and dump_start during DUMP are ignored; counting continues
        clear_all();
        load_ramp();
        snap = 1'b1; dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        snap = 1'b0; dump_start = 1'b0;
        inc = 8'hFF; en = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            check("busy_cmd_valid", 32'(dump_valid), 32'd1);
            check("busy_cmd_ch", 32'(dump_ch), 32'(k));
            check("busy_cmd_data", 32'(dump_data), 32'(k));
            snap       = (k == 2);
            dump_start = (k == 2);
            tick();
        end
        inc = '0; snap = 1'b0; dump_start = 1'b0;
        check("busy_cmd_done", 32'(dump_done), 32'd1);
        check("busy_cmd_idle", 32'(busy), 32'd0);
        tick();
        check("busy_cmd_norestart", 32'(busy), 32'd0);
        check("busy_cmd_done_once", 32'(dump_done), 32'd0);
        run_dump(1'b1, 1'b0);
        for (int i = 0; i < NUM_CH; i++) check("busy_cmd_live", 32'(cap_d[i]), 32'(i + 8));

        // reset at beat 3 aborts the dump
        clear_all();
        pulse(8'h01, 17);
        load_ramp();
        check("pre_rst_ovf", 32'(ovf), 32'h01);
        snap = 1'b1; dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        snap = 1'b0; dump_start = 1'b0;
        repeat (3) tick();
        check("rst_mid_beat", 32'(dump_ch), 32'd3);
        rst = 1'b1;
        tick();
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(dump_valid), 32'd0);
        check("rst_mid_done", 32'(dump_done), 32'd0);
        check("rst_mid_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_mid_no_done", 32'(dump_done), 32'd0);
        run_dump(1'b0, 1'b0);
        for (int i = 0; i < NUM_CH; i++) begin
            check("rst_snap_cnt", 32'(cap_d[i]), 32'd0);
            check("rst_snap_ovf", 32'(cap_o[i]), 32'd0);
        end
        run_dump(1'b1, 1'b0);
        for (int i = 0; i < NUM_CH; i++) check("rst_live_cnt", 32'(cap_d[i]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
